// File: rtl/liang_pkg.sv
// Shared types and bus widths for the IFU/LSU memory arbiter.
//   ADDR_WIDTH / DATA_WIDTH / STRB_WIDTH : AXI-lite style bus widths
//   arb_state_e : arbiter FSM states
//   arb_owner_e : which requester owns the outstanding transaction
package liang_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    StIdle,
    StRdAddr,
    StRdData,
    StWrReq,
    StWrResp
  } arb_state_e;

  typedef enum logic {
    OwnIfu,
    OwnLsu
  } arb_owner_e;

endpackage

// File: rtl/pipe_axi_arbiter.sv
// Two-master to one-slave AXI-lite arbiter: IFU (read only) and LSU (read/write)
// share a single memory port, with at most one transaction outstanding.
// Ports:
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   ifu_ar*/ifu_r*               : IFU read address / read data channels
//   lsu_ar*/lsu_r*               : LSU read address / read data channels
//   lsu_aw*/lsu_w*/lsu_b*        : LSU write address / write data / write response
//   m_ar*/m_r*/m_aw*/m_w*/m_b*   : memory-side master port (response codes not carried)
// Arbitration in IDLE: LSU write > LSU read > IFU read, except the IFU wins once it has
// watched IFU_STARVE_MAX consecutive LSU grants while waiting.
module pipe_axi_arbiter
  import liang_pkg::*;
#(
  parameter int unsigned IFU_STARVE_MAX = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic [ADDR_WIDTH-1:0] ifu_araddr_i,
  input  logic                  ifu_arvalid_i,
  output logic                  ifu_arready_o,
  output logic [DATA_WIDTH-1:0] ifu_rdata_o,
  output logic                  ifu_rvalid_o,
  input  logic                  ifu_rready_i,

  input  logic [ADDR_WIDTH-1:0] lsu_araddr_i,
  input  logic                  lsu_arvalid_i,
  output logic                  lsu_arready_o,
  output logic [DATA_WIDTH-1:0] lsu_rdata_o,
  output logic                  lsu_rvalid_o,
  input  logic                  lsu_rready_i,
  input  logic [ADDR_WIDTH-1:0] lsu_awaddr_i,
  input  logic                  lsu_awvalid_i,
  output logic                  lsu_awready_o,
  input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
  input  logic [STRB_WIDTH-1:0] lsu_wstrb_i,
  input  logic                  lsu_wvalid_i,
  output logic                  lsu_wready_o,
  output logic                  lsu_bvalid_o,
  input  logic                  lsu_bready_i,

  output logic [ADDR_WIDTH-1:0] m_araddr_o,
  output logic                  m_arvalid_o,
  input  logic                  m_arready_i,
  input  logic [DATA_WIDTH-1:0] m_rdata_i,
  input  logic                  m_rvalid_i,
  output logic                  m_rready_o,
  output logic [ADDR_WIDTH-1:0] m_awaddr_o,
  output logic                  m_awvalid_o,
  input  logic                  m_awready_i,
  output logic [DATA_WIDTH-1:0] m_wdata_o,
  output logic [STRB_WIDTH-1:0] m_wstrb_o,
  output logic                  m_wvalid_o,
  input  logic                  m_wready_i,
  input  logic                  m_bvalid_i,
  output logic                  m_bready_o
);

  localparam int unsigned StarveW = $clog2(IFU_STARVE_MAX + 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(IFU_STARVE_MAX);

  arb_state_e            state_q;
  arb_owner_e            owner_q;
  logic [StarveW-1:0]    starve_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic                  arvalid_q;
  logic                  awvalid_q;
  logic                  wvalid_q;

  logic in_idle;
  logic lsu_wr_req;
  logic ifu_force;
  logic grant_wr;
  logic grant_lsu_rd;
  logic grant_ifu;
  logic aw_done;
  logic w_done;

  // Grants are only issued out of reset so every ready reads 0 while rst_i is high.
  assign in_idle      = (state_q == StIdle) && !rst_i;
  assign lsu_wr_req   = lsu_awvalid_i && lsu_wvalid_i;
  assign ifu_force    = ifu_arvalid_i && (starve_q == StarveMax);
  assign grant_wr     = in_idle && lsu_wr_req && !ifu_force;
  assign grant_lsu_rd = in_idle && lsu_arvalid_i && !lsu_wr_req && !ifu_force;
  assign grant_ifu    = in_idle && ifu_arvalid_i &&
                        (ifu_force || (!lsu_wr_req && !lsu_arvalid_i));

  // A write channel counts as done if it already handshook or handshakes this cycle.
  assign aw_done = !awvalid_q || m_awready_i;
  assign w_done  = !wvalid_q || m_wready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      owner_q   <= OwnIfu;
      starve_q  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      arvalid_q <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_wr || grant_lsu_rd) begin
            if (ifu_arvalid_i && (starve_q != StarveMax)) begin
              starve_q <= starve_q + StarveW'(1);
            end
          end
          if (grant_wr) begin
            state_q   <= StWrReq;
            owner_q   <= OwnLsu;
            addr_q    <= lsu_awaddr_i;
            wdata_q   <= lsu_wdata_i;
            wstrb_q   <= lsu_wstrb_i;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
          end else if (grant_lsu_rd) begin
            state_q   <= StRdAddr;
            owner_q   <= OwnLsu;
            addr_q    <= lsu_araddr_i;
            arvalid_q <= 1'b1;
          end else if (grant_ifu) begin
            state_q   <= StRdAddr;
            owner_q   <= OwnIfu;
            addr_q    <= ifu_araddr_i;
            arvalid_q <= 1'b1;
            starve_q  <= '0;
          end
        end
        StRdAddr: begin
          if (m_arready_i) begin
            arvalid_q <= 1'b0;
            state_q   <= StRdData;
          end
        end
        StRdData: begin
          if (m_rvalid_i && m_rready_o) begin
            state_q <= StIdle;
          end
        end
        StWrReq: begin
          if (m_awready_i) begin
            awvalid_q <= 1'b0;
          end
          if (m_wready_i) begin
            wvalid_q <= 1'b0;
          end
          if (aw_done && w_done) begin
            state_q <= StWrResp;
          end
        end
        StWrResp: begin
          if (m_bvalid_i && lsu_bready_i) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    ifu_arready_o = grant_ifu;
    lsu_arready_o = grant_lsu_rd;
    lsu_awready_o = grant_wr;
    lsu_wready_o  = grant_wr;
    ifu_rvalid_o  = 1'b0;
    lsu_rvalid_o  = 1'b0;
    m_rready_o    = 1'b0;
    lsu_bvalid_o  = 1'b0;
    m_bready_o    = 1'b0;
    if (!rst_i) begin
      case (state_q)
        StRdData: begin
          m_rready_o   = (owner_q == OwnLsu) ? lsu_rready_i : ifu_rready_i;
          ifu_rvalid_o = (owner_q == OwnIfu) && m_rvalid_i;
          lsu_rvalid_o = (owner_q == OwnLsu) && m_rvalid_i;
        end
        StWrResp: begin
          lsu_bvalid_o = m_bvalid_i;
          m_bready_o   = lsu_bready_i;
        end
        default: ;
      endcase
    end
  end

  assign ifu_rdata_o = m_rdata_i;
  assign lsu_rdata_o = m_rdata_i;
  assign m_araddr_o  = addr_q;
  assign m_arvalid_o = arvalid_q;
  assign m_awaddr_o  = addr_q;
  assign m_awvalid_o = awvalid_q;
  assign m_wdata_o   = wdata_q;
  assign m_wstrb_o   = wstrb_q;
  assign m_wvalid_o  = wvalid_q;

endmodule

// File: tb/tb_pipe_axi_arbiter.sv
// Directed bench for pipe_axi_arbiter: the memory slave is driven by hand, cycle by cycle.
// Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
module tb_pipe_axi_arbiter;
  import liang_pkg::*;

  logic                  clk_i;
  logic                  rst_i;
  logic [ADDR_WIDTH-1:0] ifu_araddr_i;
  logic                  ifu_arvalid_i;
  logic                  ifu_arready_o;
  logic [DATA_WIDTH-1:0] ifu_rdata_o;
  logic                  ifu_rvalid_o;
  logic                  ifu_rready_i;
  logic [ADDR_WIDTH-1:0] lsu_araddr_i;
  logic                  lsu_arvalid_i;
  logic                  lsu_arready_o;
  logic [DATA_WIDTH-1:0] lsu_rdata_o;
  logic                  lsu_rvalid_o;
  logic                  lsu_rready_i;
  logic [ADDR_WIDTH-1:0] lsu_awaddr_i;
  logic                  lsu_awvalid_i;
  logic                  lsu_awready_o;
  logic [DATA_WIDTH-1:0] lsu_wdata_i;
  logic [STRB_WIDTH-1:0] lsu_wstrb_i;
  logic                  lsu_wvalid_i;
  logic                  lsu_wready_o;
  logic                  lsu_bvalid_o;
  logic                  lsu_bready_i;
  logic [ADDR_WIDTH-1:0] m_araddr_o;
  logic                  m_arvalid_o;
  logic                  m_arready_i;
  logic [DATA_WIDTH-1:0] m_rdata_i;
  logic                  m_rvalid_i;
  logic                  m_rready_o;
  logic [ADDR_WIDTH-1:0] m_awaddr_o;
  logic                  m_awvalid_o;
  logic                  m_awready_i;
  logic [DATA_WIDTH-1:0] m_wdata_o;
  logic [STRB_WIDTH-1:0] m_wstrb_o;
  logic                  m_wvalid_o;
  logic                  m_wready_i;
  logic                  m_bvalid_i;
  logic                  m_bready_o;

  int checks;
  int failures;

  pipe_axi_arbiter #(
    .IFU_STARVE_MAX(8)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .ifu_araddr_i (ifu_araddr_i),
    .ifu_arvalid_i(ifu_arvalid_i),
    .ifu_arready_o(ifu_arready_o),
    .ifu_rdata_o  (ifu_rdata_o),
    .ifu_rvalid_o (ifu_rvalid_o),
    .ifu_rready_i (ifu_rready_i),
    .lsu_araddr_i (lsu_araddr_i),
    .lsu_arvalid_i(lsu_arvalid_i),
    .lsu_arready_o(lsu_arready_o),
    .lsu_rdata_o  (lsu_rdata_o),
    .lsu_rvalid_o (lsu_rvalid_o),
    .lsu_rready_i (lsu_rready_i),
    .lsu_awaddr_i (lsu_awaddr_i),
    .lsu_awvalid_i(lsu_awvalid_i),
    .lsu_awready_o(lsu_awready_o),
    .lsu_wdata_i  (lsu_wdata_i),
    .lsu_wstrb_i  (lsu_wstrb_i),
    .lsu_wvalid_i (lsu_wvalid_i),
    .lsu_wready_o (lsu_wready_o),
    .lsu_bvalid_o (lsu_bvalid_o),
    .lsu_bready_i (lsu_bready_i),
    .m_araddr_o   (m_araddr_o),
    .m_arvalid_o  (m_arvalid_o),
    .m_arready_i  (m_arready_i),
    .m_rdata_i    (m_rdata_i),
    .m_rvalid_i   (m_rvalid_i),
    .m_rready_o   (m_rready_o),
    .m_awaddr_o   (m_awaddr_o),
    .m_awvalid_o  (m_awvalid_o),
    .m_awready_i  (m_awready_i),
    .m_wdata_o    (m_wdata_o),
    .m_wstrb_o    (m_wstrb_o),
    .m_wvalid_o   (m_wvalid_o),
    .m_wready_i   (m_wready_i),
    .m_bvalid_i   (m_bvalid_i),
    .m_bready_o   (m_bready_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_i = 1'b1;
    ifu_araddr_i = '0; ifu_arvalid_i = 1'b1; ifu_rready_i = 1'b0;
    lsu_araddr_i = '0; lsu_arvalid_i = 1'b1; lsu_rready_i = 1'b0;
    lsu_awaddr_i = '0; lsu_awvalid_i = 1'b1; lsu_wdata_i = '0; lsu_wstrb_i = '0;
    lsu_wvalid_i = 1'b1; lsu_bready_i = 1'b0;
    m_arready_i = 1'b0; m_rdata_i = '0; m_rvalid_i = 1'b1; m_awready_i = 1'b0;
    m_wready_i = 1'b0; m_bvalid_i = 1'b1;

    // Reset with every request raised: nothing may be granted or forwarded.
    tick(); tick(); #1;
    check("rst_ifu_arready", ifu_arready_o, 0);
    check("rst_lsu_arready", lsu_arready_o, 0);
    check("rst_lsu_awready", lsu_awready_o, 0);
    check("rst_lsu_wready", lsu_wready_o, 0);
    check("rst_m_arvalid", m_arvalid_o, 0);
    check("rst_m_awvalid", m_awvalid_o, 0);
    check("rst_m_wvalid", m_wvalid_o, 0);
    check("rst_m_araddr", m_araddr_o, 0);
    check("rst_m_wdata", m_wdata_o, 0);
    check("rst_ifu_rvalid", ifu_rvalid_o, 0);
    check("rst_lsu_bvalid", lsu_bvalid_o, 0);
    ifu_arvalid_i = 1'b0; lsu_arvalid_i = 1'b0; lsu_awvalid_i = 1'b0; lsu_wvalid_i = 1'b0;
    m_rvalid_i = 1'b0; m_bvalid_i = 1'b0;
    rst_i = 1'b0;
    tick();

    // IFU-only read; IFU valid drops right after the grant.
    ifu_araddr_i = 32'h8000_0000; ifu_arvalid_i = 1'b1; ifu_rready_i = 1'b1; #1;
    check("t1_ifu_arready", ifu_arready_o, 1);
    check("t1_lsu_arready", lsu_arready_o, 0);
    check("t1_m_arvalid_grant", m_arvalid_o, 0);
    tick(); ifu_arvalid_i = 1'b0; m_arready_i = 1'b1; #1;
    check("t1_m_arvalid", m_arvalid_o, 1);
    check("t1_m_araddr", m_araddr_o, 32'h8000_0000);
    check("t1_ifu_arready_busy", ifu_arready_o, 0);
    tick(); m_arready_i = 1'b0; m_rvalid_i = 1'b1; m_rdata_i = 32'h0000_0413; #1;
    check("t1_m_arvalid_off", m_arvalid_o, 0);
    check("t1_ifu_rvalid", ifu_rvalid_o, 1);
    check("t1_ifu_rdata", ifu_rdata_o, 32'h0000_0413);
    check("t1_lsu_rvalid", lsu_rvalid_o, 0);
    check("t1_m_rready", m_rready_o, 1);
    tick(); m_rvalid_i = 1'b0; #1;
    check("t1_ifu_rvalid_done", ifu_rvalid_o, 0);
    check("t1_no_second_ar_a", m_arvalid_o, 0);
    tick(); #1;
    check("t1_no_second_ar_b", m_arvalid_o, 0);

    // IFU and LSU read in the same cycle: LSU first.
    ifu_araddr_i = 32'h8000_0100; ifu_arvalid_i = 1'b1;
    lsu_araddr_i = 32'h8000_0200; lsu_arvalid_i = 1'b1; lsu_rready_i = 1'b0; #1;
    check("t2_lsu_arready", lsu_arready_o, 1);
    check("t2_ifu_arready", ifu_arready_o, 0);
    tick(); lsu_arvalid_i = 1'b0; m_arready_i = 1'b1; #1;
    check("t2_m_araddr_lsu", m_araddr_o, 32'h8000_0200);
    check("t2_ifu_wait", ifu_arready_o, 0);
    tick(); m_arready_i = 1'b0; m_rvalid_i = 1'b1; m_rdata_i = 32'h0000_0055; #1;
    check("t2_lsu_rvalid", lsu_rvalid_o, 1);
    check("t2_ifu_rvalid", ifu_rvalid_o, 0);
    check("t2_lsu_rdata", lsu_rdata_o, 32'h0000_0055);
    check("t2_m_rready_owner", m_rready_o, 0);
    tick(); lsu_rready_i = 1'b1; #1;
    check("t2_m_rready_on", m_rready_o, 1);
    tick(); m_rvalid_i = 1'b0; #1;
    check("t2_ifu_arready", ifu_arready_o, 1);
    check("t2_lsu_rvalid_off", lsu_rvalid_o, 0);
    tick(); ifu_arvalid_i = 1'b0; m_arready_i = 1'b1; #1;
    check("t2_m_araddr_ifu", m_araddr_o, 32'h8000_0100);
    tick(); m_arready_i = 1'b0; m_rvalid_i = 1'b1; m_rdata_i = 32'h0000_0066; #1;
    check("t2_ifu_rvalid_b", ifu_rvalid_o, 1);
    check("t2_lsu_rvalid_b", lsu_rvalid_o, 0);
    tick(); m_rvalid_i = 1'b0;

    // Starvation guard: 8 LSU grants, then the IFU takes the 9th arbitration.
    ifu_araddr_i = 32'h8000_0300; ifu_arvalid_i = 1'b1;
    lsu_araddr_i = 32'h8000_0400; lsu_arvalid_i = 1'b1; lsu_rready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("t4_lsu_win_%0d", i), lsu_arready_o, 1);
      check($sformatf("t4_ifu_wait_%0d", i), ifu_arready_o, 0);
      tick(); m_arready_i = 1'b1; #1;
      tick(); m_arready_i = 1'b0; m_rvalid_i = 1'b1; #1;
      tick(); m_rvalid_i = 1'b0;
    end
    #1;
    check("t4_ifu_win", ifu_arready_o, 1);
    check("t4_lsu_lose", lsu_arready_o, 0);
    tick(); m_arready_i = 1'b1; #1;
    check("t4_m_araddr_ifu", m_araddr_o, 32'h8000_0300);
    tick(); m_arready_i = 1'b0; m_rvalid_i = 1'b1; #1;
    check("t4_ifu_rvalid", ifu_rvalid_o, 1);
    tick(); m_rvalid_i = 1'b0; #1;
    check("t4_cnt_cleared_lsu", lsu_arready_o, 1);
    check("t4_cnt_cleared_ifu", ifu_arready_o, 0);
    tick(); m_arready_i = 1'b1; #1;
    tick(); m_arready_i = 1'b0; m_rvalid_i = 1'b1; #1;
    tick(); m_rvalid_i = 1'b0;

    // LSU write with a concurrent LSU read and a waiting IFU; W accepted 2 cycles after AW.
    lsu_awaddr_i = 32'h8000_1000; lsu_awvalid_i = 1'b1;
    lsu_wdata_i = 32'hDEAD_BEEF; lsu_wstrb_i = 4'hF; lsu_wvalid_i = 1'b1; #1;
    check("t3_lsu_awready", lsu_awready_o, 1);
    check("t3_lsu_wready", lsu_wready_o, 1);
    check("t3_lsu_arready", lsu_arready_o, 0);
    check("t3_ifu_arready", ifu_arready_o, 0);
    tick(); lsu_awvalid_i = 1'b0; lsu_wvalid_i = 1'b0; m_awready_i = 1'b1; #1;
    check("t3_m_awvalid", m_awvalid_o, 1);
    check("t3_m_wvalid", m_wvalid_o, 1);
    check("t3_m_awaddr", m_awaddr_o, 32'h8000_1000);
    check("t3_m_wdata", m_wdata_o, 32'hDEAD_BEEF);
    check("t3_m_wstrb", m_wstrb_o, 4'hF);
    check("t3_m_arvalid", m_arvalid_o, 0);
    check("t3_ifu_busy_a", ifu_arready_o, 0);
    tick(); m_awready_i = 1'b0; #1;
    check("t3_aw_dropped", m_awvalid_o, 0);
    check("t3_w_held_a", m_wvalid_o, 1);
    tick(); #1;
    check("t3_single_aw", m_awvalid_o, 0);
    check("t3_w_held_b", m_wvalid_o, 1);
    m_wready_i = 1'b1;
    tick(); m_wready_i = 1'b0; m_bvalid_i = 1'b1; lsu_bready_i = 1'b1; #1;
    check("t3_w_dropped", m_wvalid_o, 0);
    check("t3_lsu_bvalid", lsu_bvalid_o, 1);
    check("t3_m_bready", m_bready_o, 1);
    check("t3_ifu_busy_b", ifu_arready_o, 0);
    tick(); m_bvalid_i = 1'b0; #1;
    check("t3_lsu_bvalid_off", lsu_bvalid_o, 0);
    check("t3_pending_read", lsu_arready_o, 1);
    check("t3_ifu_still_waits", ifu_arready_o, 0);
    tick(); lsu_arvalid_i = 1'b0; m_arready_i = 1'b1; #1;
    check("t3_m_araddr_rd", m_araddr_o, 32'h8000_0400);
    tick(); m_arready_i = 1'b0; m_rvalid_i = 1'b1; #1;
    tick(); m_rvalid_i = 1'b0; #1;
    check("t3_ifu_after", ifu_arready_o, 1);

    // Reset while in RD_DATA, then a fresh IFU read.
    tick(); ifu_arvalid_i = 1'b0; m_arready_i = 1'b1; #1;
    tick(); m_arready_i = 1'b0; m_rvalid_i = 1'b1; m_rdata_i = 32'h0000_0077; #1;
    check("t5_in_rd_data", ifu_rvalid_o, 1);
    rst_i = 1'b1;
    tick(); rst_i = 1'b0; #1;
    check("t5_ifu_rvalid", ifu_rvalid_o, 0);
    check("t5_m_rready", m_rready_o, 0);
    check("t5_m_arvalid", m_arvalid_o, 0);
    check("t5_m_araddr", m_araddr_o, 0);
    m_rvalid_i = 1'b0;
    ifu_araddr_i = 32'h8000_0040; ifu_arvalid_i = 1'b1; #1;
    check("t5_ifu_arready", ifu_arready_o, 1);
    tick(); ifu_arvalid_i = 1'b0; m_arready_i = 1'b1; #1;
    check("t5_m_arvalid_new", m_arvalid_o, 1);
    check("t5_m_araddr_new", m_araddr_o, 32'h8000_0040);
    tick(); m_arready_i = 1'b0; m_rvalid_i = 1'b1; m_rdata_i = 32'h0000_0013; #1;
    check("t5_ifu_rvalid_new", ifu_rvalid_o, 1);
    check("t5_ifu_rdata_new", ifu_rdata_o, 32'h0000_0013);
    tick(); m_rvalid_i = 1'b0; #1;
    check("t5_ifu_rvalid_end", ifu_rvalid_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
